mult_seq_counter: RTL and testbench

MULT_SEQ_COUNTER -- requirements
Module: mult_seq_counter

---
 rtl/mult_seq_counter_pkg.sv | 15 +
 rtl/mult_seq_counter.sv | 85 ++++++++
 tb/tb_mult_seq_counter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mult_seq_counter_pkg.sv
// Shared multiplier control definitions: step-sequencer state encodings
// reused by the datapath control.
package mult_seq_counter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } seq_state_t;

endpackage

// File: rtl/mult_seq_counter.sv
// Step sequencer for the multiplier: counts 0..LAST while enabled, one-shot
// or free-running, with a single-cycle done pulse after a one-shot sequence.
module mult_seq_counter
  import mult_seq_counter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int LAST  = 3
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             enable,
  input  logic             mode,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  if (LAST < 1 || LAST > (2**WIDTH) - 1) begin : g_last_check
    $error("mult_seq_counter: LAST=%0d out of range 1..%0d", LAST, (2**WIDTH) - 1);
  end

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  seq_state_t       state, next_state;
  logic [WIDTH-1:0] count_q, next_count;
  logic             busy_q, done_q;

  // Wrap happens at LAST, not at the natural counter overflow.
  always_comb begin
    next_state = state;
    next_count = count_q;
    tc         = (state == ST_RUN) && enable && (count_q == LAST_V);
    if (sync_clr) begin
      next_state = ST_IDLE;
      next_count = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          next_count = '0;
          if (start || mode) next_state = ST_RUN;
        end
        ST_RUN: begin
          if (enable) begin
            if (count_q == LAST_V) begin
              next_count = '0;
              if (!mode) next_state = ST_DONE;
            end else begin
              next_count = count_q + WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          next_count = '0;
          next_state = start ? ST_RUN : ST_IDLE;
        end
        default: begin
          next_state = ST_IDLE;
          next_count = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state   <= ST_IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      count_q <= next_count;
      busy_q  <= (next_state == ST_RUN);
      done_q  <= (next_state == ST_DONE);
    end
  end

  assign count_out = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mult_seq_counter.sv
// Directed bench for mult_seq_counter: default 2-bit/LAST=3 instance plus a
// 3-bit/LAST=5 instance for the non-power-of-two wrap.
module tb_mult_seq_counter;

  logic       clk;
  logic       aclr_n;
  logic       a_start, a_enable, a_mode, a_sync_clr;
  logic [1:0] a_count;
  logic       a_busy, a_tc, a_done;
  logic       b_start, b_enable, b_mode, b_sync_clr;
  logic [2:0] b_count;
  logic       b_busy, b_tc, b_done;

  int total = 0;
  int bad   = 0;

  mult_seq_counter #(.WIDTH(2), .LAST(3)) dut_a (
    .clk(clk), .aclr_n(aclr_n), .start(a_start), .enable(a_enable),
    .mode(a_mode), .sync_clr(a_sync_clr), .count_out(a_count),
    .busy(a_busy), .tc(a_tc), .done(a_done)
  );

  mult_seq_counter #(.WIDTH(3), .LAST(5)) dut_b (
    .clk(clk), .aclr_n(aclr_n), .start(b_start), .enable(b_enable),
    .mode(b_mode), .sync_clr(b_sync_clr), .count_out(b_count),
    .busy(b_busy), .tc(b_tc), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic e, input logic m, input logic c);
    a_start    = s;
    a_enable   = e;
    a_mode     = m;
    a_sync_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkA(input string tag, input logic [1:0] cnt, input logic bsy,
                        input logic t, input logic dn);
    checkOutput({tag, ".count"}, 32'(a_count), 32'(cnt));
    checkOutput({tag, ".busy"},  32'(a_busy),  32'(bsy));
    checkOutput({tag, ".tc"},    32'(a_tc),    32'(t));
    checkOutput({tag, ".done"},  32'(a_done),  32'(dn));
  endtask

  initial begin
    aclr_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    b_start = 1'b0; b_enable = 1'b0; b_mode = 1'b0; b_sync_clr = 1'b0;

    #3;
    checkA("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    #9 aclr_n = 1'b1;
    tick();
    checkA("idle_after_reset", 2'd0, 1'b0, 1'b0, 1'b0);

    // One-shot with enable held high
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkA("os_c0", 2'd0, 1'b1, 1'b0, 1'b0);
    tick(); checkA("os_c1", 2'd1, 1'b1, 1'b0, 1'b0);
    tick(); checkA("os_c2", 2'd2, 1'b1, 1'b0, 1'b0);
    tick(); checkA("os_c3", 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); checkA("os_done", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); checkA("os_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Stall: count only moves on enabled cycles; start in RUN is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkA("st_c0", 2'd0, 1'b1, 1'b0, 1'b0);
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkA("st_c1_en0", 2'd1, 1'b1, 1'b0, 1'b0);
    tick(); checkA("st_c1_hold", 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(); applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1 checkA("st_c2_start", 2'd2, 1'b1, 1'b0, 1'b0);
    tick(); checkA("st_c2_hold", 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkA("st_c3_en0", 2'd3, 1'b1, 1'b0, 1'b0);
    tick(); checkA("st_c3_hold", 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkA("st_c3_en1", 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); checkA("st_done", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); checkA("st_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Free-run, then drop mode mid-sequence: takes effect at next terminal step
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick(); checkA("fr_c0", 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkA($sformatf("fr_step%0d", i), 2'(i % 4), 1'b1, (i % 4) == 3, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(); checkA("mc_c1", 2'd1, 1'b1, 1'b0, 1'b0);
    tick(); checkA("mc_c2", 2'd2, 1'b1, 1'b0, 1'b0);
    tick(); checkA("mc_c3", 2'd3, 1'b1, 1'b1, 1'b0);
    tick(); checkA("mc_done", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); checkA("mc_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Abort at count 2, sync_clr beating a simultaneous start
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    checkA("ab_c2", 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick(); checkA("ab_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held through DONE restarts with no IDLE gap
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    checkA("bb_c3", 2'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); checkA("bb_done", 2'd0, 1'b0, 1'b0, 1'b1);
    tick(); applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkA("bb_rerun", 2'd0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    checkA("rs_c2", 2'd2, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-count, held 40 ns, must not produce a done pulse
    #1 aclr_n = 1'b0;
    #1 checkA("rs_async", 2'd0, 1'b0, 1'b0, 1'b0);
    #39 aclr_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(); checkA("rs_idle1", 2'd0, 1'b0, 1'b0, 1'b0);
    tick(); checkA("rs_idle2", 2'd0, 1'b0, 1'b0, 1'b0);
    aclr_n = 1'b0;
    #20 aclr_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); checkA("rs_first_edge", 2'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(); checkA("rs_clr", 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=3, LAST=5 one-shot: wrap at 5, done after 6 enabled cycles
    b_start = 1'b1; b_enable = 1'b1;
    tick(); b_start = 1'b0;
    checkOutput("b_c0.count", 32'(b_count), 32'd0);
    checkOutput("b_c0.busy",  32'(b_busy),  32'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("b_c%0d.count", i), 32'(b_count), 32'(i));
      checkOutput($sformatf("b_c%0d.tc", i),    32'(b_tc),    32'(i == 5));
      checkOutput($sformatf("b_c%0d.done", i),  32'(b_done),  32'd0);
    end
    tick();
    checkOutput("b_done.done",  32'(b_done),  32'd1);
    checkOutput("b_done.count", 32'(b_count), 32'd0);
    checkOutput("b_done.busy",  32'(b_busy),  32'd0);
    tick();
    checkOutput("b_idle.done", 32'(b_done), 32'd0);
    checkOutput("b_idle.busy", 32'(b_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
